mnist_img_loader: RTL and testbench
===================================

Name: mnist_img_loader

Overview:
Host-side initiator for mnist_accel. Accepts a pixel byte stream over a valid/ready handshake and assembles the 784-byte image vector. Pulses start to the accelerator, waits for done, then returns pred_digit to the consumer over a second valid/ready handshake. Sits between the DMA/UART byte source and mnist_accel.

Parameters:
N_PIX, 784, pixels per image
PIX_W, 8, bits per pixel
TIMEOUT_CYC, 65536, cycles to wait for done before flagging an error (used only with the optional feature)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
s_data  in  PIX_W  pixel byte
s_valid  in  1  pixel byte valid
s_ready  out  1  loader can accept a pixel
acc_img_data  out  N_PIX*PIX_W  image vector to mnist_accel.img_data
acc_start  out  1  one-cycle start pulse to mnist_accel
acc_done  in  1  mnist_accel.done
acc_pred  in  4  mnist_accel.pred_digit
res_digit  out  4  classified digit
res_err  out  1  result is a timeout error (always 0 without the optional feature)
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
busy  out  1  high in every state except LOAD with a pixel count of 0
img_cnt  out  16  number of images classified; wraps at 2^16

Behaviour:
- Reset: the following outputs are 0:
  - s_ready, acc_start, res_valid, res_digit, res_err, busy, img_cnt, acc_img_data
  - internal pixel counter and done_q
  - state is LOAD.
- One cycle after reset deasserts, s_ready is 1.
- Reset mid-operation aborts immediately and discards partial images and pending results. The loader does not reset the accelerator.
- States: LOAD, START, WAIT, RESULT.
- LOAD:
  - s_ready = 1.
  - On s_valid && s_ready, the byte goes to acc_img_data[pix_cnt*PIX_W +: PIX_W]. Pixel 0 occupies the LSBs.
  - pix_cnt increments on each accepted byte.
  - On the handshake with pix_cnt == N_PIX-1: go to START and clear pix_cnt.
- START:
  - acc_start = 1 for exactly one cycle, then go to WAIT.
  - The last pixel is accepted in cycle N; acc_start is high in cycle N+1.
- WAIT:
  - s_ready = 0. acc_img_data is held stable from START until leaving WAIT.
  - done_q registers acc_done every cycle.
  - When acc_done && !done_q (rising edge): latch acc_pred into res_digit, clear res_err, go to RESULT.
  - If acc_done is already high on WAIT entry (stale level), the loader ignores it until it falls and rises again.
- RESULT:
  - res_valid = 1, held with res_digit stable until res_ready.
  - A rising edge in cycle D gives res_valid = 1 in cycle D+1.
  - On res_valid && res_ready: img_cnt increments (wraps 0xFFFF -> 0) and the state returns to LOAD. s_ready is 1 the next cycle.
  - If res_ready is already high when res_valid rises, the transfer completes in that same cycle.
- s_valid while s_ready = 0 is ignored. The source must hold the byte.
- acc_pred is sampled only on the done rising edge. Changes at other times are ignored.

Optional Feature:
MNIST_LOADER_TIMEOUT_EN
- Defined:
  - A counter clears on entering WAIT and increments each WAIT cycle.
  - On reaching TIMEOUT_CYC-1 without a done edge: res_digit = 4'hF, res_err = 1, go to RESULT. img_cnt still increments on transfer.
  - A done edge in the same cycle as expiry wins: normal result, res_err = 0.
- Undefined:
  - No counter. WAIT waits forever and res_err is tied to 0.

Decomposition:
- Package mnist_pkg holds:
  - N_PIX, PIX_W, IMG_W = N_PIX*PIX_W, DIGIT_W = 4, ERR_DIGIT = 4'hF
  - loader state enum {LOAD, START, WAIT, RESULT}
- One sub-module, mnist_pix_assembler: pixel counter, byte-lane write into the image register, and a last-pixel flag.
- The FSM, done edge detection, timeout and result register stay in mnist_img_loader.

Test Plan:
- Reset -> all outputs 0 during reset; s_ready = 1 the cycle after release; busy = 0.
- Stream 784 bytes with value i mod 256, s_valid always high -> acc_img_data[i*8 +: 8] == i mod 256 for all i; acc_start high exactly one cycle, one cycle after the 784th handshake; s_ready = 0 afterwards.
- Mock accelerator raises done 50 cycles after start with pred = 6 -> res_digit = 6 and res_valid = 1 on the next cycle; img_cnt becomes 1 after res_ready.
- Hold res_ready low for 10 cycles, then high -> res_valid and res_digit stable throughout; single transfer; s_ready = 1 the next cycle; s_valid presented during WAIT is not accepted (pixel count unchanged).
- Assert rst at pixel 300 of an image, then stream a full new image with pred 2 -> no acc_start from the aborted image; the new image classifies as 2; img_cnt = 1.
- With MNIST_LOADER_TIMEOUT_EN and TIMEOUT_CYC = 100, done never asserted -> res_valid after 100 WAIT cycles with res_digit = 0xF and res_err = 1.

Source files
------------

// File: rtl/mnist_pkg.sv
// Shared constants and state type for the MNIST image loader.
package mnist_pkg;

  localparam int unsigned N_PIX   = 784;
  localparam int unsigned PIX_W   = 8;
  localparam int unsigned IMG_W   = N_PIX * PIX_W;
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned CNT_W   = $clog2(N_PIX);

  localparam logic [DIGIT_W-1:0] ERR_DIGIT = 4'hF;

  typedef enum logic [1:0] {
    StLoad,
    StStart,
    StWait,
    StResult
  } loader_state_e;

endpackage

// File: rtl/mnist_pix_assembler.sv
// Pixel counter and byte-lane writer that builds the flat image vector.
module mnist_pix_assembler
  import mnist_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [PIX_W-1:0] data_i,
  output logic [IMG_W-1:0] img_o,
  output logic [CNT_W-1:0] pix_cnt_o,
  output logic             last_o
);

  logic [IMG_W-1:0] img_q;
  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;

  assign last_o    = (pix_cnt_q == CNT_W'(N_PIX - 1));
  assign img_o     = img_q;
  assign pix_cnt_o = pix_cnt_q;

  always_comb begin
    pix_cnt_d = pix_cnt_q;
    if (wr_en_i) begin
      pix_cnt_d = last_o ? '0 : pix_cnt_q + 1'b1;
    end
  end

  // Pixel 0 lands in the LSBs of the vector.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      img_q     <= '0;
      pix_cnt_q <= '0;
    end else begin
      pix_cnt_q <= pix_cnt_d;
      if (wr_en_i) begin
        img_q[pix_cnt_q*PIX_W +: PIX_W] <= data_i;
      end
    end
  end

endmodule

// File: rtl/mnist_img_loader.sv
// Streams an image into mnist_accel, kicks it off and hands back the digit.
// Optional done-timeout enabled by defining MNIST_LOADER_TIMEOUT_EN.
module mnist_img_loader
  import mnist_pkg::*;
`ifdef MNIST_LOADER_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYC = 65536
)
`endif
(
  input  logic               clk,
  input  logic               rst,
  input  logic [PIX_W-1:0]   s_data,
  input  logic               s_valid,
  output logic               s_ready,
  output logic [IMG_W-1:0]   acc_img_data,
  output logic               acc_start,
  input  logic               acc_done,
  input  logic [DIGIT_W-1:0] acc_pred,
  output logic [DIGIT_W-1:0] res_digit,
  output logic               res_err,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               busy,
  output logic [15:0]        img_cnt
);

  loader_state_e        state_q, state_d;
  logic                 s_ready_q, done_q, done_rise;
  logic                 pix_wr, pix_last;
  logic [CNT_W-1:0]     pix_cnt;
  logic [DIGIT_W-1:0]   res_digit_q, res_digit_d;
  logic [15:0]          img_cnt_q, img_cnt_d;

`ifdef MNIST_LOADER_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT_CYC);
  logic           res_err_q, res_err_d;
  logic [ToW-1:0] to_cnt_q, to_cnt_d;
  logic           to_expire;
  assign to_expire = (to_cnt_q == ToW'(TIMEOUT_CYC - 1));
`endif

  assign pix_wr    = s_valid & s_ready_q;
  // Edge rather than level so a done left high from a previous run is ignored.
  assign done_rise = acc_done & ~done_q;

  mnist_pix_assembler u_pix_asm (
    .clk_i     (clk),
    .rst_i     (rst),
    .wr_en_i   (pix_wr),
    .data_i    (s_data),
    .img_o     (acc_img_data),
    .pix_cnt_o (pix_cnt),
    .last_o    (pix_last)
  );

  always_comb begin
    state_d     = state_q;
    res_digit_d = res_digit_q;
    img_cnt_d   = img_cnt_q;
`ifdef MNIST_LOADER_TIMEOUT_EN
    res_err_d   = res_err_q;
    to_cnt_d    = (state_q == StWait) ? to_cnt_q + 1'b1 : '0;
`endif
    unique case (state_q)
      StLoad: begin
        if (pix_wr && pix_last) state_d = StStart;
      end
      StStart: state_d = StWait;
      StWait: begin
        if (done_rise) begin
          res_digit_d = acc_pred;
          state_d     = StResult;
`ifdef MNIST_LOADER_TIMEOUT_EN
          res_err_d   = 1'b0;
        end else if (to_expire) begin
          res_digit_d = ERR_DIGIT;
          res_err_d   = 1'b1;
          state_d     = StResult;
`endif
        end
      end
      StResult: begin
        if (res_ready) begin
          img_cnt_d = img_cnt_q + 16'd1;
          state_d   = StLoad;
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StLoad;
      s_ready_q   <= 1'b0;
      done_q      <= 1'b0;
      res_digit_q <= '0;
      img_cnt_q   <= '0;
`ifdef MNIST_LOADER_TIMEOUT_EN
      res_err_q   <= 1'b0;
      to_cnt_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      s_ready_q   <= (state_d == StLoad);
      done_q      <= acc_done;
      res_digit_q <= res_digit_d;
      img_cnt_q   <= img_cnt_d;
`ifdef MNIST_LOADER_TIMEOUT_EN
      res_err_q   <= res_err_d;
      to_cnt_q    <= to_cnt_d;
`endif
    end
  end

  assign s_ready   = s_ready_q;
  assign acc_start = (state_q == StStart);
  assign res_valid = (state_q == StResult);
  assign res_digit = res_digit_q;
  assign img_cnt   = img_cnt_q;
  assign busy      = !((state_q == StLoad) && (pix_cnt == '0));
`ifdef MNIST_LOADER_TIMEOUT_EN
  assign res_err   = res_err_q;
`else
  assign res_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mnist_img_loader.sv
// Self-checking bench for mnist_img_loader with a mock accelerator and result scoreboard.
module tb_mnist_img_loader;
  import mnist_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic [PIX_W-1:0]   s_data;
  logic               s_valid;
  logic               s_ready;
  logic [IMG_W-1:0]   acc_img_data;
  logic               acc_start;
  logic               acc_done;
  logic [DIGIT_W-1:0] acc_pred;
  logic [DIGIT_W-1:0] res_digit;
  logic               res_err;
  logic               res_valid;
  logic               res_ready;
  logic               busy;
  logic [15:0]        img_cnt;

  int n_chk = 0;
  int n_err = 0;
  int n_start = 0;
  int n_xfer = 0;
  int mock_delay = 50;
  logic [3:0] mock_pred = 4'd6;
  logic mock_en = 1'b1;
  logic [4:0] exp_q[$];

  always #5 clk = ~clk;

`ifdef MNIST_LOADER_TIMEOUT_EN
  mnist_img_loader #(.TIMEOUT_CYC(100)) dut (
`else
  mnist_img_loader dut (
`endif
    .clk          (clk),
    .rst          (rst),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .acc_img_data (acc_img_data),
    .acc_start    (acc_start),
    .acc_done     (acc_done),
    .acc_pred     (acc_pred),
    .res_digit    (res_digit),
    .res_err      (res_err),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .busy         (busy),
    .img_cnt      (img_cnt)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int mode, input int i);
    case (mode)
      0:       return 8'(i);
      1:       return 8'(i * 7 + 3);
      default: return 8'(255 - i);
    endcase
  endfunction

  task automatic send_image(input int mode, input int count);
    logic acc;
    int   guard;
    for (int i = 0; i < count; i++) begin
      s_valid = 1'b1;
      s_data  = pat(mode, i);
      guard   = 0;
      do begin
        acc = s_ready;
        @(posedge clk); #1;
        guard++;
      end while (!acc && guard < 100);
      if (!acc) begin
        check_val("s_ready_stuck", 32'(acc), 32'd1);
        break;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_res(input int start, output int lat);
    lat = start;
    while (!res_valid && lat < 2000) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!res_valid) check_val("res_timeout", 32'(res_valid), 32'd1);
  endtask

  // Mock accelerator: raises done mock_delay cycles after start, then scrambles pred.
  initial begin
    acc_done = 1'b0;
    acc_pred = '0;
    forever begin
      @(posedge clk); #1;
      if (acc_start && mock_en) begin
        repeat (mock_delay) @(posedge clk);
        #1;
        acc_done = 1'b1;
        acc_pred = mock_pred;
        repeat (3) @(posedge clk);
        #1;
        acc_pred = 4'd9;
        repeat (3) @(posedge clk);
        #1;
        acc_done = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (acc_start) n_start++;
    if (!rst && res_valid && res_ready) begin
      n_xfer++;
      if (exp_q.size() == 0) begin
        check_val("sb_unexpected", 32'd1, 32'd0);
      end else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        check_val("sb_digit", 32'(res_digit), 32'(e[3:0]));
        check_val("sb_err", 32'(res_err), 32'(e[4]));
      end
    end
  end

  initial begin
    int lat;
    int s0;
    int x0;
    logic stable;
    rst = 1'b1; s_valid = 1'b0; s_data = '0; res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_s_ready", 32'(s_ready), 32'd0);
    check_val("rst_start", 32'(acc_start), 32'd0);
    check_val("rst_res_valid", 32'(res_valid), 32'd0);
    check_val("rst_digit", 32'(res_digit), 32'd0);
    check_val("rst_err", 32'(res_err), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_img_cnt", 32'(img_cnt), 32'd0);
    check_val("rst_img", 32'(|acc_img_data), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_val("post_rst_s_ready", 32'(s_ready), 32'd1);
    check_val("post_rst_busy", 32'(busy), 32'd0);

    // Image 1: ramp data, pred 6, consumer stalls 10 cycles.
    s0 = n_start;
    send_image(0, N_PIX);
    exp_q.push_back({1'b0, 4'd6});
    check_val("start_hi", 32'(acc_start), 32'd1);
    @(posedge clk); #1;
    check_val("start_lo", 32'(acc_start), 32'd0);
    check_val("wait_s_ready", 32'(s_ready), 32'd0);
    check_val("wait_busy", 32'(busy), 32'd1);
    check_val("start_count1", 32'(n_start - s0), 32'd1);
    for (int i = 0; i < N_PIX; i++) begin
      check_val($sformatf("img1_px%0d", i), 32'(acc_img_data[i*PIX_W +: PIX_W]), 32'(pat(0, i)));
    end
    s_valid = 1'b1;
    s_data  = 8'hAA;
    wait_res(1, lat);
    check_val("done_lat", 32'(lat), 32'd51);
    stable = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (res_valid !== 1'b1 || res_digit !== 4'd6) stable = 1'b0;
    end
    check_val("res_stable", 32'(stable), 32'd1);
    s_valid = 1'b0;
    check_val("wait_px_ignored", 32'(acc_img_data[7:0]), 32'd0);
    x0 = n_xfer;
    res_ready = 1'b1;
    @(posedge clk); #1;
    check_val("xfer_valid_lo", 32'(res_valid), 32'd0);
    check_val("xfer_s_ready", 32'(s_ready), 32'd1);
    check_val("xfer_busy", 32'(busy), 32'd0);
    check_val("img_cnt1", 32'(img_cnt), 32'd1);
    check_val("xfer_single", 32'(n_xfer - x0), 32'd1);

    // Image 2: res_ready already high, transfer completes on the first RESULT cycle.
    mock_pred = 4'd3;
    send_image(1, N_PIX);
    exp_q.push_back({1'b0, 4'd3});
    @(posedge clk); #1;
    check_val("img2_px0", 32'(acc_img_data[7:0]), 32'(pat(1, 0)));
    check_val("img2_px783", 32'(acc_img_data[IMG_W-1 -: 8]), 32'(pat(1, N_PIX - 1)));
    wait_res(1, lat);
    check_val("done_lat2", 32'(lat), 32'd51);
    @(posedge clk); #1;
    check_val("img2_valid_lo", 32'(res_valid), 32'd0);
    check_val("img_cnt2", 32'(img_cnt), 32'd2);

    // Abort at pixel 300, then a fresh image classified as 2.
    res_ready = 1'b0;
    s0 = n_start;
    send_image(2, 300);
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_val("abort_s_ready", 32'(s_ready), 32'd0);
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_img_cnt", 32'(img_cnt), 32'd0);
    check_val("abort_img", 32'(|acc_img_data), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_val("abort_no_start", 32'(n_start - s0), 32'd0);
    mock_pred = 4'd2;
    send_image(2, N_PIX);
    exp_q.push_back({1'b0, 4'd2});
    @(posedge clk); #1;
    wait_res(1, lat);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check_val("abort_img_cnt1", 32'(img_cnt), 32'd1);
    check_val("abort_start1", 32'(n_start - s0), 32'd1);

`ifdef MNIST_LOADER_TIMEOUT_EN
    mock_en = 1'b0;
    send_image(0, N_PIX);
    exp_q.push_back({1'b1, 4'hF});
    @(posedge clk); #1;
    wait_res(1, lat);
    check_val("to_lat", 32'(lat), 32'd101);
    check_val("to_err", 32'(res_err), 32'd1);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check_val("to_img_cnt", 32'(img_cnt), 32'd2);
`endif

    check_val("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
